// File: rtl/exmem_pkg.sv
// Shared EX/MEM definitions: default field widths and the packed control-field
// layout used by this stage, the MEM stage and the hazard unit.
package exmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int MW_W_DEF   = 2;
  localparam int MR_W_DEF   = 3;

  // Control fields travel MSB-first in this order everywhere in the pipeline.
  typedef struct packed {
    logic                memtoreg;
    logic                regwrite;
    logic [MW_W_DEF-1:0] memwrite;
    logic [MR_W_DEF-1:0] memread;
  } exmem_ctrl_t;

  localparam int CTRL_W_DEF = $bits(exmem_ctrl_t);

  // Total payload width: control fields, address, store data, destination.
  function automatic int payload_w(input int dw, input int aw, input int mw, input int mr);
    return 2 + mw + mr + 2 * dw + aw;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry skid buffer: a head register that drives the output and a
// skid register that absorbs one transfer while the consumer stalls. The
// upstream ready is registered so no combinational path crosses the stage.
module pipe_skid_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic                 r_head_vld;
  logic                 r_skid_vld;
  logic                 r_in_ready;
  logic [PAYLOAD_W-1:0] r_head;
  logic [PAYLOAD_W-1:0] r_skid;

  logic w_accept;
  logic w_head_free;

  assign w_accept    = i_valid & r_in_ready;
  // Head can take a new entry when it is empty or being consumed this cycle.
  assign w_head_free = ~r_head_vld | i_ready;

  // Head/skid update; skid only fills while head is stalled, so it is never
  // valid with an empty head and order is preserved by draining skid first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else if (i_flush) begin
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_head_free) begin
      if (r_skid_vld) begin
        r_head     <= r_skid;
        r_head_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_head_vld <= w_accept;
        if (w_accept) begin
          r_head <= i_data;
        end
      end
      r_in_ready <= 1'b1;
    end else if (w_accept) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
      r_in_ready <= 1'b0;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_head_vld;
  assign o_data  = r_head;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with skid buffering and forwarding outputs for the
// hazard unit. Control fields are forced to zero on bubbles so MEM never acts
// on stale controls.
module exmem_skid_stage
  import exmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int MW_W   = MW_W_DEF,
  parameter int MR_W   = MR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [MW_W-1:0]   in_memwrite,
  input  logic [MR_W-1:0]   in_memread,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_AW-1:0] in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [MW_W-1:0]   out_memwrite,
  output logic [MR_W-1:0]   out_memread,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_AW-1:0] out_dst,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dst,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_is_load
);

  localparam int PAYLOAD_W = payload_w(DATA_W, REG_AW, MW_W, MR_W);

  logic [PAYLOAD_W-1:0] w_in_pl;
  logic [PAYLOAD_W-1:0] w_out_pl;
  logic                 w_head_vld;
  logic                 w_memtoreg;
  logic                 w_regwrite;
  logic [MW_W-1:0]      w_memwrite;
  logic [MR_W-1:0]      w_memread;

  // Payload packs control fields first, in the shared control-field order.
  assign w_in_pl = {in_memtoreg, in_regwrite, in_memwrite, in_memread,
                    in_addr, in_wdata, in_dst};

  pipe_skid_reg #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_flush(flush),
    .i_valid(in_valid),
    .o_ready(in_ready),
    .i_data (w_in_pl),
    .o_valid(w_head_vld),
    .i_ready(out_ready),
    .o_data (w_out_pl)
  );

  assign {w_memtoreg, w_regwrite, w_memwrite, w_memread,
          out_addr, out_wdata, out_dst} = w_out_pl;

  assign out_valid    = w_head_vld;
  assign out_memtoreg = w_head_vld & w_memtoreg;
  assign out_regwrite = w_head_vld & w_regwrite;
  assign out_memwrite = {MW_W{w_head_vld}} & w_memwrite;
  assign out_memread  = {MR_W{w_head_vld}} & w_memread;

  // Register 0 is hardwired, so writes to it never forward.
  assign fwd_valid   = out_regwrite & (out_dst != '0);
  assign fwd_dst     = out_dst;
  assign fwd_data    = out_addr;
  assign fwd_is_load = fwd_valid & out_memtoreg;

endmodule

// File: tb/tb_exmem_skid_stage.sv
module tb_exmem_skid_stage;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [1:0]  mw;
    logic [2:0]  mr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  dst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  ent_t drv = '0;

  logic        in_ready, out_valid;
  logic        out_memtoreg, out_regwrite;
  logic [1:0]  out_memwrite;
  logic [2:0]  out_memread;
  logic [63:0] out_addr, out_wdata, fwd_data;
  logic [4:0]  out_dst, fwd_dst;
  logic        fwd_valid, fwd_is_load;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered list of accepted instructions, at most two.
  ent_t q[$];
  bit   m_rdy_en = 1'b0;

  exmem_skid_stage #(
    .DATA_W(64), .REG_AW(5), .MW_W(2), .MR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_memtoreg(drv.m2r), .in_regwrite(drv.rw), .in_memwrite(drv.mw),
    .in_memread(drv.mr), .in_addr(drv.addr), .in_wdata(drv.wdata), .in_dst(drv.dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite),
    .out_memwrite(out_memwrite), .out_memread(out_memread),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_dst(out_dst),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .fwd_is_load(fwd_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] a, input logic rw, input logic m2r,
                              input logic [4:0] d);
    ent_t e;
    e.m2r   = m2r;
    e.rw    = rw;
    e.mw    = a[3:2];
    e.mr    = a[6:4];
    e.addr  = a;
    e.wdata = a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    e.dst   = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      q.delete();
      m_rdy_en = 1'b0;
    end else begin
      acc = in_valid && m_rdy_en && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(drv);
      end
      m_rdy_en = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    ent_t e;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_addr", out_addr, 64'h0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(m_rdy_en && q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        e = q[0];
        chk("ctrl", 64'({out_memtoreg, out_regwrite, out_memwrite, out_memread}),
            64'({e.m2r, e.rw, e.mw, e.mr}));
        chk("addr", out_addr, e.addr);
        chk("wdata", out_wdata, e.wdata);
        chk("dst", 64'(out_dst), 64'(e.dst));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.rw && e.dst != 5'd0));
        chk("fwd_is_load", 64'(fwd_is_load), 64'(e.rw && e.dst != 5'd0 && e.m2r));
        chk("fwd_data", fwd_data, e.addr);
        chk("fwd_dst", 64'(fwd_dst), 64'(e.dst));
      end else begin
        chk("bubble_ctrl", 64'({out_memtoreg, out_regwrite, out_memwrite, out_memread}), 64'h0);
        chk("bubble_fwd", 64'({fwd_valid, fwd_is_load}), 64'h0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset
    rst = 1'b1;
    repeat (2) tick();
    chk("d_rst_in_ready", 64'(in_ready), 64'h0);
    chk("d_rst_out_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    tick();
    chk("d_post_rst_in_ready", 64'(in_ready), 64'h1);
    chk("d_post_rst_out_valid", 64'(out_valid), 64'h0);

    // Streaming at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv = mk(64'h10 + 64'(4 * i), 1'b1, 1'b0, 5'd3);
      tick();
      chk("d_stream_addr", out_addr, 64'h10 + 64'(4 * i));
      chk("d_stream_valid", 64'(out_valid), 64'h1);
      chk("d_stream_ready", 64'(in_ready), 64'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("d_stream_end", 64'(out_valid), 64'h0);

    // Stall fills skid, then drains in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drv = mk(64'h20, 1'b1, 1'b0, 5'd7);
    tick();
    chk("d_stall_head", out_addr, 64'h20);
    chk("d_stall_ready1", 64'(in_ready), 64'h1);
    drv = mk(64'h24, 1'b1, 1'b0, 5'd8);
    tick();
    chk("d_stall_ready0", 64'(in_ready), 64'h0);
    chk("d_stall_head_held", out_addr, 64'h20);
    drv = mk(64'h99, 1'b1, 1'b0, 5'd9);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("d_drain_second", out_addr, 64'h24);
    chk("d_drain_ready", 64'(in_ready), 64'h1);
    tick();
    chk("d_drain_empty", 64'(out_valid), 64'h0);

    // Flush with both entries full and a simultaneous input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drv = mk(64'h30, 1'b1, 1'b0, 5'd9);
    tick();
    drv = mk(64'h34, 1'b1, 1'b1, 5'd10);
    tick();
    chk("d_full_ready", 64'(in_ready), 64'h0);
    flush = 1'b1;
    drv = mk(64'h38, 1'b1, 1'b0, 5'd11);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("d_flush_valid", 64'(out_valid), 64'h0);
    chk("d_flush_ctrl", 64'({out_regwrite, out_memwrite, out_memread}), 64'h0);
    chk("d_flush_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("d_flush_nothing", 64'(out_valid), 64'h0);

    // Forwarding
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drv = mk(64'h50, 1'b1, 1'b0, 5'd0);
    tick();
    chk("d_fwd_r0_valid", 64'(fwd_valid), 64'h0);
    chk("d_fwd_r0_out_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    drv = mk(64'h40, 1'b1, 1'b1, 5'd5);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("d_fwd_valid", 64'(fwd_valid), 64'h1);
    chk("d_fwd_dst", 64'(fwd_dst), 64'h5);
    chk("d_fwd_data", fwd_data, 64'h40);
    chk("d_fwd_is_load", 64'(fwd_is_load), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("d_fwd_cleared", 64'(fwd_valid), 64'h0);

    // Asynchronous reset mid-stall with skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drv = mk(64'h60, 1'b1, 1'b0, 5'd12);
    tick();
    drv = mk(64'h64, 1'b1, 1'b0, 5'd13);
    tick();
    in_valid = 1'b0;
    chk("d_arst_pre_full", 64'(in_ready), 64'h0);
    #2 rst = 1'b1;
    #1;
    chk("d_arst_valid", 64'(out_valid), 64'h0);
    chk("d_arst_ctrl", 64'({out_memtoreg, out_regwrite, out_memwrite, out_memread}), 64'h0);
    chk("d_arst_addr", out_addr, 64'h0);
    chk("d_arst_wdata", out_wdata, 64'h0);
    chk("d_arst_dst", 64'(out_dst), 64'h0);
    chk("d_arst_fwd", 64'({fwd_valid, fwd_is_load}), 64'h0);
    chk("d_arst_in_ready", 64'(in_ready), 64'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("d_arst_release_ready", 64'(in_ready), 64'h1);
    chk("d_arst_release_valid", 64'(out_valid), 64'h0);
    tick();
    chk("d_arst_no_stale", 64'(out_valid), 64'h0);

    // Random handshake traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drv.m2r   = 1'($urandom);
      drv.rw    = 1'($urandom);
      drv.mw    = 2'($urandom);
      drv.mr    = 3'($urandom);
      drv.addr  = {$urandom, $urandom};
      drv.wdata = {$urandom, $urandom};
      drv.dst   = 5'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("d_rand_drained_valid", 64'(out_valid), 64'h0);
    chk("d_rand_drained_ready", 64'(in_ready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exmem_skid_stage.md
EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of ALU address and store-data fields.
REQ-002 SHALL provide parameter REG_AW, default 5, width of destination register index.
REQ-003 SHALL provide parameter MW_W, default 2, width of memory-write control field.
REQ-004 SHALL provide parameter MR_W, default 3, width of memory-read control field.
REQ-005 SHALL provide ports, in this order:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  synchronous kill of all held instructions
- in_memtoreg / in_regwrite  in  1 each  write-back controls
- in_memwrite  in  MW_W  store-size control
- in_memread  in  MR_W  load-size/sign control
- in_addr  in  DATA_W  ALU result / data address
- in_wdata  in  DATA_W  store data (rt value)
- in_dst  in  REG_AW  destination index (rd or rt)
- out_valid  out  1  MEM stage sees a valid instruction
- out_ready  in  1  MEM stage consumes this cycle
- out_* (memtoreg, regwrite, memwrite, memread, addr, wdata, dst)  out  widths as inputs
- fwd_valid  out  1  head entry writes a register with non-zero dst
- fwd_dst  out  REG_AW  forwarding destination index
- fwd_data  out  DATA_W  forwarding value (out_addr)
- fwd_is_load  out  1  head entry result not yet available (memtoreg=1)

Function
REQ-006 SHALL hold up to two entries: head (drives out_*) and skid (overflow).
REQ-007 SHALL accept an instruction on a rising edge when in_valid=1 and in_ready=1.
REQ-008 SHALL drive in_ready from a register: in_ready=1 exactly when skid entry is empty.
REQ-009 SHALL present an accepted instruction on out_* one cycle after acceptance when head is empty or consumed in that cycle (latency 1, full throughput).
REQ-010 SHALL place an accepted instruction in skid when head is valid and out_ready=0 in the acceptance cycle.
REQ-011 SHALL move skid into head on the cycle head is consumed (out_valid=1, out_ready=1), preserving order.
REQ-012 SHALL never drop, duplicate or reorder an accepted instruction absent flush.
REQ-013 SHALL force out_regwrite, out_memwrite, out_memread and out_memtoreg to zero whenever out_valid=0 (bubble); payload fields may hold stale values.
REQ-014 SHALL, on flush=1, clear head and skid valid bits at that edge, ignore any simultaneous acceptance, and assert in_ready the following cycle.
REQ-015 SHALL treat flush with simultaneous consumption as flush (consumed entry counts as delivered to MEM).
REQ-016 SHALL drive fwd_valid = out_valid & out_regwrite & (out_dst != 0); fwd_dst=out_dst; fwd_data=out_addr; fwd_is_load = fwd_valid & out_memtoreg.
REQ-017 SHALL pass all fields bit-exact; no arithmetic on payload.

Reset
REQ-018 SHALL, while rst=1, clear head/skid valid, all payload and control registers to zero, and hold in_ready=0.
REQ-019 SHALL set in_ready=1 on the first rising edge after rst deasserts; reset mid-transfer discards all entries.

Structure
REQ-020 SHALL take DATA_W, REG_AW, MW_W, MR_W defaults and the packed control-field layout from shared package exmem_pkg, also used by the MEM stage and hazard unit.
REQ-021 SHALL implement the two-entry buffer as one generic sub-module pipe_skid_reg (parameter PAYLOAD_W) instantiated once with the concatenated payload.

Verification
REQ-022 SHALL cover: reset then in_valid=1 continuous, out_ready=1, addr 0x10,0x14,0x18 -> out_addr same sequence one cycle later, out_valid unbroken, in_ready=1 throughout.
REQ-023 SHALL cover: head holds addr 0x20, out_ready=0, accept 0x24 -> in_ready=0 next cycle; raise out_ready -> 0x20 then 0x24 delivered, in_ready returns 1.
REQ-024 SHALL cover: both entries full, flush=1 with in_valid=1 -> out_valid=0 and out_regwrite/memwrite/memread=0 next cycle, in_ready=1, flushed input never appears.
REQ-025 SHALL cover: head with regwrite=1, dst=0 -> fwd_valid=0; dst=5, memtoreg=1, addr 0x40 -> fwd_valid=1, fwd_dst=5, fwd_data=0x40, fwd_is_load=1.
REQ-026 SHALL cover: rst asserted asynchronously mid-stall with skid full -> all outputs zero immediately, in_ready=1 first edge after release, no stale entry emerges.
REQ-027 SHALL cover: random in_valid/out_ready (10k cycles, DATA_W=64 build) against scoreboard -> exact in-order delivery, zero losses.
